fetch_sequencer: RTL and testbench

- Control FSM that sequences instruction fetch for the 16-bit RISC core.
- Issues a memory read request and waits for acknowledge. Loads the returned word into the instruction register via its load strobe and increments the PC.
- Hands the decoded instruction to the execute stage with a start/done handshake. Detects the HALT opcode and memory timeouts.
- Sits between instruction memory, PC, instruction register and execute control.

---
 rtl/risc_ctrl_pkg.sv | 29 ++
 rtl/ack_timer.sv | 49 ++++
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// risc_ctrl_pkg
// Shared control definitions for the 16-bit RISC core front end.
//   - state_e        : fetch sequencer state encoding (debug-visible via state_o)
//   - *_DEF constants: default instruction/opcode geometry and HALT opcode,
//                      reused by the sequencer and the instruction decoder
//   - ACK_TIMER_WIDTH: width of the memory-acknowledge timeout counter
// -----------------------------------------------------------------------------
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_DECODE = 3'd4,
    ST_EXEC   = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_e;

  localparam int               INSTR_WIDTH_DEF  = 16;
  localparam int               OPCODE_WIDTH_DEF = 4;
  localparam logic [3:0]       HALT_OPCODE_DEF  = 4'hF;

  // Timeout limit is at most 255 cycles, so 8 bits always suffice.
  localparam int               ACK_TIMER_WIDTH  = 8;

endpackage : risc_ctrl_pkg

// File: rtl/ack_timer.sv
// -----------------------------------------------------------------------------
// ack_timer
// Loadable up-counter with a terminal flag, used while waiting for mem_ack.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   clr_i   - clear the count to zero (has priority over inc_i)
//   inc_i   - increment the count by one
//   last_o  - high when the current wait cycle is the last one allowed,
//             i.e. count == LIMIT-1; a miss in this cycle means timeout
// -----------------------------------------------------------------------------
module ack_timer
  import risc_ctrl_pkg::*;
#(
  parameter int WIDTH = ACK_TIMER_WIDTH,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count holds the number of wait cycles already missed, so the Nth
  // wait cycle sees N-1 here.
  assign last_o = (cnt_q == WIDTH'(LIMIT - 1));

endmodule : ack_timer

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Control FSM sequencing instruction fetch: memory request/ack, IR load and
// PC increment, opcode decode (HALT detection), execute start/done handshake,
// ack timeout fault and a retired-instruction counter.
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-low reset
//   run           - 1 = keep sequencing, 0 = stop at next instruction boundary
//   mem_req       - memory read request (REQ and WAIT)
//   mem_ack       - memory acknowledge, only looked at in WAIT
//   ir_ld, pc_inc - one-cycle strobes in LOAD
//   ir_q          - instruction register contents, decoded in DECODE
//   exec_start    - one-cycle execute start pulse in DECODE (non-HALT)
//   exec_done     - execute completion, only looked at in EXEC
//   halted        - sticky HALT indication
//   fetch_err     - sticky ack-timeout fault
//   state_o       - current state encoding
//   instr_count   - retired instruction count (HALT included), wraps
// -----------------------------------------------------------------------------
module fetch_sequencer
  import risc_ctrl_pkg::*;
#(
  parameter int                      INSTR_WIDTH  = INSTR_WIDTH_DEF,
  parameter int                      OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = HALT_OPCODE_DEF,
  parameter int                      ACK_TIMEOUT  = 15,
  parameter int                      CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic                   ir_ld,
  output logic                   pc_inc,
  input  logic [INSTR_WIDTH-1:0] ir_q,
  output logic                   exec_start,
  input  logic                   exec_done,
  output logic                   halted,
  output logic                   fetch_err,
  output logic [2:0]             state_o,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  state_e                state_q;
  state_e                state_d;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  tmr_clr;
  logic                  tmr_inc;
  logic                  tmr_last;
  logic                  is_halt;
  logic                  ir_operand_unused;

  // ir_q comes straight from the instruction register, so decoding it here
  // still only depends on registered state.
  assign is_halt           = (ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
  assign ir_operand_unused = ^ir_q[INSTR_WIDTH-OPCODE_WIDTH-1:0];

  ack_timer #(
    .WIDTH (ACK_TIMER_WIDTH),
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .last_o (tmr_last)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_REQ;
      end
      ST_REQ: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Ack is tested first so a late ack on the final cycle still loads.
        if (mem_ack) begin
          state_d = ST_LOAD;
        end else if (tmr_last) begin
          state_d = ST_FAULT;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_halt) begin
          state_d = ST_HALT;
          count_d = count_q + 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          count_d = count_q + 1'b1;
          state_d = run ? ST_REQ : ST_IDLE;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign mem_req     = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign ir_ld       = (state_q == ST_LOAD);
  assign pc_inc      = (state_q == ST_LOAD);
  assign exec_start  = (state_q == ST_DECODE) && !is_halt;
  assign halted      = (state_q == ST_HALT);
  assign fetch_err   = (state_q == ST_FAULT);
  assign state_o     = state_q;
  assign instr_count = count_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic        ir_ld;
  logic        pc_inc;
  logic [15:0] ir_reg;
  logic        exec_start;
  logic        exec_done = 1'b0;
  logic        halted;
  logic        fetch_err;
  logic [2:0]  state_o;
  logic [3:0]  instr_count;

  logic [15:0] mem_word = 16'h0000;
  logic [3:0]  sb_count = 4'd0;
  logic [3:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_sequencer #(
    .ACK_TIMEOUT (15),
    .CNT_WIDTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .ir_ld       (ir_ld),
    .pc_inc      (pc_inc),
    .ir_q        (ir_reg),
    .exec_start  (exec_start),
    .exec_done   (exec_done),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .state_o     (state_o),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Instruction register model: captures the memory word on the load strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) ir_reg <= 16'h0000;
    else if (ir_ld) ir_reg <= mem_word;
  end

  function automatic logic [8:0] obs();
    return {state_o, mem_req, ir_ld, pc_inc, exec_start, halted, fetch_err};
  endfunction

  function automatic logic [8:0] ob(input logic [2:0] st, input logic req, input logic ld,
                                    input logic start, input logic hlt, input logic err);
    return {st, req, ld, ld, start, hlt, err};
  endfunction

  task automatic do_reset();
    rst = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    @(negedge clk); @(negedge clk);
    sb_count = 4'd0;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs one instruction starting from a negedge in REQ. Pushes the expected
  // retired count when the fetch is issued, pops it at retirement.
  task automatic run_instr(input logic [15:0] word, input int ack_wait, input int done_wait,
                           input bit drop_run, input bit spur_decode, input string tag);
    logic [8:0] got;
    logic [8:0] want;
    logic [3:0] exp_cnt;
    bit         hlt;
    hlt = (word[15:12] == 4'hF);
    sb_count = sb_count + 4'd1;
    exp_q.push_back(sb_count);
    mem_word = word;
    want = ob(3'd1, 1, 0, 0, 0, 0); got = obs(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL %s/req: got %b want %b", tag, got, want); end
    for (int i = 0; i <= ack_wait; i++) begin
      @(negedge clk);
      if (drop_run && i == 0) run = 1'b0;
      want = ob(3'd2, 1, 0, 0, 0, 0); got = obs(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL %s/wait%0d: got %b want %b", tag, i, got, want); end
      mem_ack = (i == ack_wait);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    want = ob(3'd3, 0, 1, 0, 0, 0); got = obs(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL %s/load: got %b want %b", tag, got, want); end
    @(negedge clk);
    want = ob(3'd4, 0, 0, !hlt, 0, 0); got = obs(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL %s/decode: got %b want %b", tag, got, want); end
    if (spur_decode) exec_done = 1'b1;
    if (hlt) begin
      @(negedge clk);
      exec_done = 1'b0;
      want = ob(3'd6, 0, 0, 0, 1, 0); got = obs(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL %s/halt: got %b want %b", tag, got, want); end
    end else begin
      for (int j = 0; j <= done_wait; j++) begin
        @(negedge clk);
        want = ob(3'd5, 0, 0, 0, 0, 0); got = obs(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL %s/exec%0d: got %b want %b", tag, j, got, want); end
        exec_done = (j == done_wait);
      end
      @(negedge clk);
      exec_done = 1'b0;
      want = ob(run ? 3'd1 : 3'd0, run, 0, 0, 0, 0); got = obs(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL %s/next: got %b want %b", tag, got, want); end
    end
    exp_cnt = exp_q.pop_front();
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++; $display("FAIL %s/count: got %0d want %0d", tag, instr_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1; mem_ack = 1'b1; exec_done = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({obs(), instr_count} !== 13'd0) begin
      n_bad++; $display("FAIL reset_hold: got %b want 0", {obs(), instr_count});
    end
    rst = 1'b1; mem_ack = 1'b0; exec_done = 1'b0;
    sb_count = 4'd0;
    @(negedge clk);
    n_cmp++;
    if (state_o !== 3'd1) begin n_bad++; $display("FAIL reset_exit: got %0d want 1", state_o); end
  endtask

  task automatic test_single();
    run_instr(16'h1234, 0, 1, 0, 0, "single");
  endtask

  task automatic test_halt();
    logic [8:0] want;
    run_instr(16'hF000, 0, 0, 0, 0, "halt");
    mem_ack = 1'b1; exec_done = 1'b1;
    want = ob(3'd6, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== want || instr_count !== 4'd2) begin
        n_bad++; $display("FAIL halt_sticky%0d: got %b/%0d want %b/2", i, obs(), instr_count, want);
      end
    end
    mem_ack = 1'b0; exec_done = 1'b0;
  endtask

  task automatic test_timeout();
    logic [8:0] want;
    run = 1'b1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      want = ob(3'd2, 1, 0, 0, 0, 0); n_cmp++;
      if (obs() !== want) begin n_bad++; $display("FAIL timeout_wait%0d: got %b want %b", i, obs(), want); end
    end
    want = ob(3'd7, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      n_cmp++;
      if (obs() !== want) begin n_bad++; $display("FAIL timeout_fault%0d: got %b want %b", i, obs(), want); end
    end
    mem_ack = 1'b0;
    do_reset();
    run_instr(16'h2345, 14, 0, 0, 0, "late_ack");
  endtask

  task automatic test_run_drop();
    run = 1'b1;
    do_reset();
    run_instr(16'h0042, 2, 1, 1, 0, "run_drop");
    for (int i = 0; i < 3; i++) begin
      exec_done = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (state_o !== 3'd0 || instr_count !== sb_count) begin
        n_bad++; $display("FAIL idle_spur%0d: got %0d/%0d want 0/%0d", i, state_o, instr_count, sb_count);
      end
    end
    exec_done = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run_instr(16'h0777, 0, 0, 0, 0, "resume");
  endtask

  task automatic test_wrap();
    run = 1'b1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_instr({4'h1, 12'(i)}, i % 2, i % 3, 0, (i == 3), "wrap");
    end
    n_cmp++;
    if (instr_count !== 4'd1) begin n_bad++; $display("FAIL wrap_final: got %0d want 1", instr_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_halt();
    test_timeout();
    test_run_drop();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_sequencer
